// File: rtl/ds_load_store_agen_if.sv
// Bundle between the DS-form decoder, GPR read port, load/store pipe and the agen.
// No latency of its own: plain wires grouped for port lists.
// Flow control lives in the agen: stall_o toward decode, enable_o/ready_i toward LdSt.
interface ds_load_store_agen_if #(
    parameter int regWidth  = 5,
    parameter int immWidth  = 14,
    parameter int addrWidth = 64
);
    // decoded op stream
    logic                 enable_i;
    logic [regWidth-1:0]  reg1_i;
    logic [regWidth-1:0]  reg2_i;
    logic                 reg2ValOrZero_i;
    logic [immWidth-1:0]  imm_i;
    logic [1:0]           functionalUnitCode_i;
    logic                 stall_o;
    // GPR read port
    logic                 regReadEnable_o;
    logic [regWidth-1:0]  regReadAddr_o;
    logic                 regReadValid_i;
    logic [addrWidth-1:0] regReadData_i;
    // load/store pipe output
    logic                 enable_o;
    logic                 ready_i;
    logic [addrWidth-1:0] ea_o;
    logic [regWidth-1:0]  dataReg_o;
    logic                 update_o;
    logic [regWidth-1:0]  updateReg_o;
    logic                 invalid_o;

    // the agen's view
    modport slave (
        input  enable_i, reg1_i, reg2_i, reg2ValOrZero_i, imm_i, functionalUnitCode_i,
        output stall_o,
        output regReadEnable_o, regReadAddr_o,
        input  regReadValid_i, regReadData_i,
        output enable_o, ea_o, dataReg_o, update_o, updateReg_o, invalid_o,
        input  ready_i
    );

    // the surrounding pipeline's view
    modport master (
        output enable_i, reg1_i, reg2_i, reg2ValOrZero_i, imm_i, functionalUnitCode_i,
        input  stall_o,
        input  regReadEnable_o, regReadAddr_o,
        output regReadValid_i, regReadData_i,
        input  enable_o, ea_o, dataReg_o, update_o, updateReg_o, invalid_o,
        output ready_i
    );
endinterface

// File: rtl/ds_load_store_agen.sv
// DS-form load/store effective-address generator: buffers ops, reads RA, emits EA = base + sext({DS,00}).
// Latency: enable_o from the cycle after capture edge +2 (literal-zero base) or +3 plus GPR wait cycles.
// Backpressure: stall_o while the op buffer is full; the output is held stable until ready_i.
module ds_load_store_agen #(
    parameter int         regWidth     = 5,
    parameter int         immWidth     = 14,
    parameter int         addrWidth    = 64,
    parameter int         fifoDepth    = 2,
    parameter logic [1:0] LdStUnitCode = 2'd2
) (
    input  logic                clock_i,
    input  logic                reset_i,
    ds_load_store_agen_if.slave agen_if
);

    localparam int PtrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
    localparam int CntW = $clog2(fifoDepth + 1);

    typedef struct packed {
        logic [regWidth-1:0] reg1;
        logic [regWidth-1:0] reg2;
        logic                valOrZero;
        logic [immWidth-1:0] imm;
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // op buffer
    op_t            mem_q [fifoDepth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;
    logic            fresh_q;
    logic            push;
    logic            pop;
    logic            head_vld;
    op_t             head;

    // FSM and registered outputs
    state_t               state_q;
    logic                 rd_en_q;
    logic [regWidth-1:0]  rd_addr_q;
    logic                 out_vld_q;
    logic [addrWidth-1:0] ea_q;
    logic [regWidth-1:0]  data_reg_q;
    logic                 upd_q;
    logic [regWidth-1:0]  upd_reg_q;
    logic                 inv_q;

    logic [addrWidth-1:0] offset;
    logic                 literal_base;

    assign push = agen_if.enable_i
                  && (agen_if.functionalUnitCode_i == LdStUnitCode)
                  && (count_q < CntW'(fifoDepth));
    assign pop  = (state_q == OUTPUT) && agen_if.ready_i;
    assign head = mem_q[rd_ptr_q];

    // An entry becomes readable on the cycle after its write edge, so an entry
    // written by the previous edge (fresh_q) is excluded from the visible count.
    // Older entries are always ahead of it, so this only matters when it is alone.
    assign head_vld = (count_q > CntW'(fresh_q));

    // DS immediate: bit 0 in IBM numbering is the MSB and carries the sign.
    assign offset = {{(addrWidth-immWidth-2){head.imm[immWidth-1]}}, head.imm, 2'b00};
    assign literal_base = head.valOrZero && (head.reg2 == '0);

    // occupancy next-state; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // op buffer storage, pointers and occupancy
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < fifoDepth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fresh_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{reg1:      agen_if.reg1_i,
                                     reg2:      agen_if.reg2_i,
                                     valOrZero: agen_if.reg2ValOrZero_i,
                                     imm:       agen_if.imm_i};
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
            fresh_q <= push;
        end
    end

    // IDLE -> (READ ->) OUTPUT -> IDLE, all outputs registered
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            out_vld_q  <= 1'b0;
            ea_q       <= '0;
            data_reg_q <= '0;
            upd_q      <= 1'b0;
            upd_reg_q  <= '0;
            inv_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (head_vld) begin
                        if (literal_base) begin
                            // RA==0 in the literal-zero form: no GPR read needed
                            ea_q       <= offset;
                            out_vld_q  <= 1'b1;
                            data_reg_q <= head.reg1;
                            upd_q      <= 1'b0;
                            upd_reg_q  <= head.reg2;
                            inv_q      <= 1'b0;
                            state_q    <= OUTPUT;
                        end else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= head.reg2;
                            state_q   <= READ;
                        end
                    end
                end
                READ: begin
                    if (agen_if.regReadValid_i) begin
                        rd_en_q    <= 1'b0;
                        ea_q       <= agen_if.regReadData_i + offset;
                        out_vld_q  <= 1'b1;
                        data_reg_q <= head.reg1;
                        upd_q      <= ~head.valOrZero;
                        upd_reg_q  <= head.reg2;
                        // update form with RA==0 is architecturally invalid; consumer traps
                        inv_q      <= ~head.valOrZero & (head.reg2 == '0);
                        state_q    <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (agen_if.ready_i) begin
                        out_vld_q <= 1'b0;
                        upd_q     <= 1'b0;
                        inv_q     <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign agen_if.stall_o         = (count_q == CntW'(fifoDepth));
    assign agen_if.regReadEnable_o = rd_en_q;
    assign agen_if.regReadAddr_o   = rd_addr_q;
    assign agen_if.enable_o        = out_vld_q;
    assign agen_if.ea_o            = ea_q;
    assign agen_if.dataReg_o       = data_reg_q;
    assign agen_if.update_o        = upd_q;
    assign agen_if.updateReg_o     = upd_reg_q;
    assign agen_if.invalid_o       = inv_q;

endmodule

// File: tb/tb_ds_load_store_agen.sv
// Self-checking bench for ds_load_store_agen: directed vector table, hand sequences, random vs queue model.
// Inputs driven and outputs sampled on the falling clock edge.
// A register-file model answers GPR reads with configurable or random wait cycles.
module tb_ds_load_store_agen;

    logic clk;
    logic rst;

    ds_load_store_agen_if #(.regWidth(5), .immWidth(14), .addrWidth(64)) bus ();

    ds_load_store_agen dut (
        .clock_i (clk),
        .reset_i (rst),
        .agen_if (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // register-file model controls
    bit          rand_mode = 1'b0;
    int          rf_wait   = 0;
    logic [63:0] rf_val    = '0;
    bit          rf_pulse  = 1'b0;
    logic [63:0] gpr [32];

    typedef struct {
        logic [4:0]  reg1;
        logic [4:0]  reg2;
        logic        voz;
        logic [13:0] imm;
    } op_t;

    typedef struct {
        logic [4:0]  reg1;
        logic [4:0]  reg2;
        logic        voz;
        logic [13:0] imm;
        logic [63:0] gpr_val;
        int          rd_wait;
        logic [63:0] exp_ea;
        logic        exp_upd;
        logic        exp_inv;
        int          exp_lat;
        int          exp_rd;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.stall_o, bus.regReadEnable_o, bus.regReadAddr_o, bus.enable_o,
                    bus.dataReg_o, bus.update_o, bus.updateReg_o, bus.invalid_o})
               | bus.ea_o;
    endfunction

    // EA from the architectural rule: base (0 or GPR[RA]) plus the DS field times four
    function automatic logic [63:0] model_ea(input op_t o);
        logic signed [13:0] s;
        longint             base;
        s    = o.imm;
        base = (o.voz && o.reg2 == 5'd0) ? 64'sd0 : longint'(gpr[o.reg2]);
        return 64'(base + longint'(s) * 4);
    endfunction

    task automatic drive_op(input logic [4:0] r1, input logic [4:0] r2, input logic voz,
                            input logic [13:0] imm, input logic [1:0] fu);
        bus.enable_i             = 1'b1;
        bus.reg1_i               = r1;
        bus.reg2_i               = r2;
        bus.reg2ValOrZero_i      = voz;
        bus.imm_i                = imm;
        bus.functionalUnitCode_i = fu;
    endtask

    // GPR read-port responder
    initial begin : rf_model
        bit req_seen;
        int wcnt;
        req_seen = 1'b0;
        wcnt     = 0;
        bus.regReadValid_i = 1'b0;
        bus.regReadData_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.regReadEnable_o) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    wcnt = rand_mode ? int'($urandom_range(0, 3)) : rf_wait;
                end
                if (wcnt == 0) begin
                    bus.regReadValid_i = 1'b1;
                    bus.regReadData_i  = rand_mode ? gpr[bus.regReadAddr_o] : rf_val;
                end else begin
                    bus.regReadValid_i = 1'b0;
                    bus.regReadData_i  = {$urandom, $urandom};
                    wcnt--;
                end
            end else begin
                req_seen = 1'b0;
                bus.regReadValid_i = rf_pulse || (rand_mode && $urandom_range(0, 7) == 0);
                bus.regReadData_i  = {$urandom, $urandom};
            end
        end
    end

    initial begin : main
        vec_t vecs [6];
        op_t  q [$];
        op_t  o;
        int   lat, rd, seen, n_out;
        bit   addr_ok, acc, rdy;

        vecs[0] = '{5'd3,  5'd0, 1'b1, 14'h0004, 64'h0,                   0, 64'h10,   1'b0, 1'b0, 2, 0};
        vecs[1] = '{5'd4,  5'd5, 1'b1, 14'h3FFF, 64'h1000,                3, 64'h0FFC, 1'b0, 1'b0, 6, 4};
        vecs[2] = '{5'd8,  5'd7, 1'b0, 14'h0001, 64'h20,                  0, 64'h24,   1'b1, 1'b0, 3, 1};
        vecs[3] = '{5'd8,  5'd0, 1'b0, 14'h0001, 64'h40,                  0, 64'h44,   1'b1, 1'b1, 3, 1};
        vecs[4] = '{5'd2,  5'd9, 1'b1, 14'h0001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,    1'b0, 1'b0, 3, 1};
        vecs[5] = '{5'd31, 5'd1, 1'b1, 14'h2000, 64'h1_0000,              1, 64'h8000, 1'b0, 1'b0, 4, 2};

        rst = 1'b1;
        bus.enable_i = 1'b0;
        bus.reg1_i = '0;
        bus.reg2_i = '0;
        bus.reg2ValOrZero_i = 1'b0;
        bus.imm_i = '0;
        bus.functionalUnitCode_i = '0;
        bus.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 6; i++) begin
            rf_val  = vecs[i].gpr_val;
            rf_wait = vecs[i].rd_wait;
            bus.ready_i = 1'b1;
            drive_op(vecs[i].reg1, vecs[i].reg2, vecs[i].voz, vecs[i].imm, 2'd2);
            @(negedge clk);
            bus.enable_i = 1'b0;
            lat = 0;
            rd = 0;
            addr_ok = 1'b1;
            while (!bus.enable_o && lat < 40) begin
                if (bus.regReadEnable_o) begin
                    rd++;
                    if (bus.regReadAddr_o !== vecs[i].reg2) addr_ok = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_read_cycles", i), 64'(rd), 64'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_read_addr", i), 64'(addr_ok), 64'd1);
            chk($sformatf("vec%0d_ea", i), bus.ea_o, vecs[i].exp_ea);
            chk($sformatf("vec%0d_fields", i),
                64'({bus.dataReg_o, bus.update_o, bus.updateReg_o, bus.invalid_o}),
                64'({vecs[i].reg1, vecs[i].exp_upd, vecs[i].reg2, vecs[i].exp_inv}));
            @(negedge clk);
            chk($sformatf("vec%0d_popped", i), 64'({bus.enable_o, bus.update_o, bus.invalid_o}), 64'h0);
        end

        // ---------------- back-pressure, unit-code filter, drop ----------------
        bus.ready_i = 1'b0;
        drive_op(5'd10, 5'd0, 1'b1, 14'd2, 2'd2);            // A
        @(negedge clk);
        drive_op(5'd20, 5'd0, 1'b1, 14'd5, 2'd0);            // filtered
        chk("bp_stall_after_A", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        drive_op(5'd21, 5'd0, 1'b1, 14'd6, 2'd3);            // filtered
        chk("bp_stall_after_fu0", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        drive_op(5'd11, 5'd0, 1'b1, 14'd3, 2'd2);            // B
        chk("bp_stall_after_fu3", 64'(bus.stall_o), 64'd0);
        @(negedge clk);
        drive_op(5'd12, 5'd0, 1'b1, 14'd4, 2'd2);            // C, must be dropped
        chk("bp_stall_after_B", 64'(bus.stall_o), 64'd1);
        @(negedge clk);
        bus.enable_i = 1'b0;
        chk("bp_stall_hold", 64'(bus.stall_o), 64'd1);
        chk("bp_A_out", 64'({bus.enable_o, bus.dataReg_o}), 64'({1'b1, 5'd10}));
        chk("bp_A_ea", bus.ea_o, 64'h8);
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_stall_after_pop", 64'(bus.stall_o), 64'd0);
        lat = 0;
        while (!bus.enable_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_B_out", 64'({bus.enable_o, bus.dataReg_o}), 64'({1'b1, 5'd11}));
        chk("bp_B_ea", bus.ea_o, 64'hC);
        @(negedge clk);
        seen = 0;
        repeat (10) begin
            if (bus.enable_o || bus.regReadEnable_o) seen++;
            @(negedge clk);
        end
        chk("bp_no_extra_ops", 64'(seen), 64'd0);

        // ---------------- reset while a GPR read is outstanding ----------------
        rf_wait = 50;
        drive_op(5'd13, 5'd6, 1'b1, 14'd0, 2'd2);
        @(negedge clk);
        bus.enable_i = 1'b0;
        lat = 0;
        while (!bus.regReadEnable_o && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_read_started", 64'(bus.regReadEnable_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midread_outputs", all_outputs(), 64'h0);
        rst = 1'b0;
        rf_pulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rf_pulse = 1'b0;
        seen = 0;
        repeat (8) begin
            if (bus.enable_o || bus.regReadEnable_o || bus.stall_o) seen++;
            @(negedge clk);
        end
        chk("rst_no_activity", 64'(seen), 64'd0);
        chk("rst_final_outputs", all_outputs(), 64'h0);
        rf_wait = 0;

        // ---------------- randomized run against the queue model ----------------
        for (int i = 0; i < 32; i++) gpr[i] = {$urandom, $urandom};
        gpr[31] = 64'hFFFF_FFFF_FFFF_FFFC;
        rand_mode = 1'b1;
        n_out = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (c < 5800) begin
                rdy = ($urandom_range(0, 2) != 0);
                bus.enable_i = ($urandom_range(0, 1) == 1);
                bus.reg1_i = 5'($urandom);
                bus.reg2_i = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                bus.reg2ValOrZero_i = 1'($urandom);
                bus.imm_i = 14'($urandom);
                bus.functionalUnitCode_i = ($urandom_range(0, 3) != 0) ? 2'd2 : 2'($urandom);
            end else begin
                rdy = 1'b1;
                bus.enable_i = 1'b0;
            end
            bus.ready_i = rdy;

            chk("rand_stall", 64'(bus.stall_o), 64'(q.size() == 2));
            if (!bus.enable_o) chk("rand_idle_flags", 64'({bus.update_o, bus.invalid_o}), 64'h0);
            if (bus.regReadEnable_o) begin
                if (q.size() == 0) chk("rand_read_with_empty_model", 64'd1, 64'd0);
                else chk("rand_read_addr", 64'(bus.regReadAddr_o), 64'(q[0].reg2));
            end

            acc = bus.enable_i && bus.functionalUnitCode_i == 2'd2 && q.size() < 2;
            if (bus.enable_o && rdy) begin
                if (q.size() == 0) begin
                    chk("rand_output_with_empty_model", 64'd1, 64'd0);
                end else begin
                    o = q.pop_front();
                    chk("rand_ea", bus.ea_o, model_ea(o));
                    chk("rand_fields",
                        64'({bus.dataReg_o, bus.update_o, bus.updateReg_o, bus.invalid_o}),
                        64'({o.reg1, ~o.voz, o.reg2, (~o.voz && o.reg2 == 5'd0)}));
                    n_out++;
                end
            end
            if (acc) q.push_back('{bus.reg1_i, bus.reg2_i, bus.reg2ValOrZero_i, bus.imm_i});
        end
        chk("rand_drained", 64'(q.size()), 64'd0);
        chk("rand_ops_seen", 64'(n_out > 200), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ds_load_store_agen.md
Name: ds_load_store_agen

Overview:
Consumes the decoded DS-format load/store stream (reg1/reg2/reg2ValOrZero/imm/functionalUnitCode/enable) and produces effective addresses for the load/store unit.
Buffers decoded ops in a small FIFO and back-pressures the decoder via stall_o. Reads the base GPR (RA) through a request/valid register-file port. Emits EA, the data register (RT/RS) and an update-form RA writeback request to the downstream LdSt pipe under a valid/ready handshake.

Parameters:
regWidth, 5, GPR address width
immWidth, 14, DS immediate width (before the 2'b00 append)
addrWidth, 64, EA and GPR data width
fifoDepth, 2, decoded-op buffer entries (power of two, >=2)
LdStUnitCode, 2, functional unit code accepted; all other codes ignored

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  asynchronous, active-high reset
enable_i  in  1  decoded op valid
reg1_i  in  regWidth  RT/RS field
reg2_i  in  regWidth  RA field
reg2ValOrZero_i  in  1  1: RA==0 means literal zero; 0: update form
imm_i  in  immWidth  DS field, bit 0 = sign
functionalUnitCode_i  in  2  dispatch unit code
stall_o  out  1  FIFO full; upstream must hold/stop issuing
regReadEnable_o  out  1  GPR read request
regReadAddr_o  out  regWidth  GPR read address
regReadValid_i  in  1  GPR read data valid
regReadData_i  in  addrWidth  GPR read data
enable_o  out  1  EA output valid
ready_i  in  1  downstream accepts output
ea_o  out  addrWidth  effective address
dataReg_o  out  regWidth  RT/RS passthrough
update_o  out  1  write ea_o back to updateReg_o
updateReg_o  out  regWidth  RA for update writeback
invalid_o  out  1  update form with RA==0 (invalid form), qualified by enable_o

Behaviour:
- Reset (async, any cycle): FIFO emptied, count=0, state IDLE. All outputs 0. A register-file response pending at reset is discarded (valid is not sampled in IDLE).
- Push: on the rising edge where enable_i=1, functionalUnitCode_i==LdStUnitCode and count<fifoDepth, capture {reg1, reg2, reg2ValOrZero, imm}. Other unit codes are ignored. An input arriving while full is dropped; the upstream must respect stall_o.
- stall_o = (count==fifoDepth), derived from registered count.
- Push and pop in the same edge: count unchanged; FIFO order preserved.
- offset = sign-extend to addrWidth of {imm, 2'b00}. EA = base + offset, modulo 2^addrWidth; wrap-around is silent.
- FSM states are IDLE, READ and OUTPUT.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head has reg2ValOrZero=1 and reg2==0: base=0, register EA, go to OUTPUT. No register read is issued.
  - Otherwise: go to READ.
- READ:
  - regReadEnable_o=1 and regReadAddr_o=head.reg2, held stable until regReadValid_i.
  - regReadValid_i is sampled every READ cycle, including the first, and may arrive the same cycle as the request.
  - On valid: EA = regReadData_i + offset, registered; go to OUTPUT.
- OUTPUT:
  - enable_o=1; ea_o, dataReg_o=head.reg1, update_o=~head.reg2ValOrZero and updateReg_o=head.reg2 all held stable.
  - invalid_o = ~head.reg2ValOrZero & (head.reg2==0).
  - On ready_i=1: pop the head, go to IDLE.
- Update form with RA==0 still reads GPR0 and asserts update_o; invalid_o lets the consumer trap.
- Latency, literal-zero base: op captured at edge N, enable_o high from cycle after edge N+2.
- Latency, register base with 0-cycle read response: enable_o high from cycle after edge N+3.
- Throughput: at most one op per 2 cycles (literal) or 3 cycles (register, 0-wait).
- Outside OUTPUT: enable_o=0, update_o=0, invalid_o=0. Data outputs are don't-care but hold their last value.

Test Plan:
- Reset/literal zero: reset, push ld reg1=3 reg2=0 valOrZero=1 imm=14'h0004 → no regReadEnable_o; enable_o ea=0x10, dataReg=3, update_o=0 two cycles after capture.
- Register base, negative offset: push reg2=5 imm=14'h3FFF; GPR5=0x1000 returned after 3 wait cycles → regReadAddr_o=5 held 4 cycles; ea=0x0FFC.
- Update form / invalid: push valOrZero=0 reg2=7 imm=1, GPR7=0x20 → ea=0x24, update_o=1, updateReg=7, invalid_o=0. Repeat with reg2=0 → invalid_o=1.
- Back-pressure: hold ready_i=0, push 3 ops → stall_o=1 after 2nd accept; 3rd dropped. Release ready_i → ops 1 and 2 emerge in order; stall_o drops the cycle after the first pop.
- Wrap and filter: GPR=0xFFFF_FFFF_FFFF_FFFC, imm=1 → ea=0. Push with functionalUnitCode=0 → FIFO count unchanged, no output.
- Reset mid-READ: assert reset_i while regReadEnable_o=1, then regReadValid_i pulses → all outputs 0, no enable_o, FIFO empty, stall_o=0.
